// File: rtl/ysyx_25020047_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ysyx_25020047_ctrl_fsm
//   Multi-cycle sequencer for the NPC core. Walks each instruction through
//   fetch, decode, execute, memory and writeback. Runs valid/ready handshakes
//   to instruction and data memory. Issues one-cycle enables for the IR latch,
//   the register-file write and the PC update. Stops on ebreak (HALT), or on an
//   illegal opcode or a memory timeout (ERR).
//
// Parameters
//   MEM_TIMEOUT : number of response-less cycles allowed in FETCH_WAIT/MEM_WAIT
//                 before ERR; 0 disables the timeout
//   CNT_W       : width of the performance counters
//
// Ports
//   clk, rst_n                     core clock / async active-low reset
//   imem_req_valid/ready           instruction fetch request handshake
//   imem_rsp_valid                 fetched word present on IR input
//   inst_latch_en                  capture fetched word into IR (Mealy)
//   opcode, is_ebreak              decoder view of the IR
//   dmem_req_valid/ready, dmem_we  data request handshake, 1 = store
//   dmem_rsp_valid                 load data valid / store done
//   rf_we, pc_we                   writeback enables
//   halted, err                    sticky terminal status
//   cyc_cnt, inst_cnt              active-cycle / retired-instruction counters
//
// Build option
//   YSYX_25020047_PERF_CNT_EN : when defined, cyc_cnt/inst_cnt count; when
//   undefined they are tied to zero and no counter flops exist.
//
// state      | meaning
// IDLE       | first cycle after reset
// FETCH_REQ  | imem request raised, waiting for ready
// FETCH_WAIT | waiting for instruction word
// DECODE     | ebreak / legality check
// EXEC       | route to memory or writeback
// MEM_REQ    | dmem request raised, waiting for ready
// MEM_WAIT   | waiting for load data / store ack
// WB         | pc_we, rf_we
// HALT       | ebreak reached, terminal
// ERR        | illegal opcode or timeout, terminal
// ----------------------------------------------------------------------------
module ysyx_25020047_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    output logic             inst_latch_en,
    input  logic [6:0]       opcode,
    input  logic             is_ebreak,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_we,
    input  logic             dmem_rsp_valid,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Counter only needs to reach MEM_TIMEOUT-1 before the ERR transition.
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_legal;
    logic            w_is_mem;
    logic            w_wait_idle;
    logic            w_wait_entry;
    logic            w_to_expire;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

    assign w_wait_idle  = ((r_state == S_FETCH_WAIT) && !imem_rsp_valid) ||
                          ((r_state == S_MEM_WAIT)   && !dmem_rsp_valid);
    assign w_wait_entry = ((r_state == S_FETCH_REQ) && imem_req_ready) ||
                          ((r_state == S_MEM_REQ)   && dmem_req_ready);
    // The increment made in this cycle would reach MEM_TIMEOUT.
    assign w_to_expire  = (MEM_TIMEOUT != 0) && w_wait_idle && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_wait_entry) begin
            r_to_cnt <= '0;
        end else if (w_wait_idle) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = S_FETCH_REQ;
            S_FETCH_REQ:  if (imem_req_ready) w_next = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (imem_rsp_valid)   w_next = S_DECODE;
                else if (w_to_expire) w_next = S_ERR;
            end
            S_DECODE: begin
                if (is_ebreak)     w_next = S_HALT;
                else if (!w_legal) w_next = S_ERR;
                else               w_next = S_EXEC;
            end
            S_EXEC:       w_next = w_is_mem ? S_MEM_REQ : S_WB;
            S_MEM_REQ:    if (dmem_req_ready) w_next = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (dmem_rsp_valid)   w_next = S_WB;
                else if (w_to_expire) w_next = S_ERR;
            end
            S_WB:         w_next = S_FETCH_REQ;
            S_HALT:       w_next = S_HALT;
            S_ERR:        w_next = S_ERR;
            default:      w_next = S_ERR;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        inst_latch_en  = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_we        = 1'b0;
        rf_we          = 1'b0;
        pc_we          = 1'b0;
        halted         = 1'b0;
        err            = 1'b0;
        case (r_state)
            S_FETCH_REQ:  imem_req_valid = 1'b1;
            S_FETCH_WAIT: inst_latch_en  = imem_rsp_valid;
            S_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                dmem_we        = (opcode == OP_STORE);
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = (opcode != OP_STORE) && (opcode != OP_BRANCH);
            end
            S_HALT:       halted = 1'b1;
            S_ERR:        err    = 1'b1;
            default: ;
        endcase
    end

`ifdef YSYX_25020047_PERF_CNT_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_inst_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR)) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            end
            if (r_state == S_WB) begin
                r_inst_cnt <= r_inst_cnt + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt  = r_cyc_cnt;
    assign inst_cnt = r_inst_cnt;
`else
    assign cyc_cnt  = '0;
    assign inst_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_25020047_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25020047_ctrl_fsm
//   Bench for the core sequencer. The stimulus side plays imem/dmem with random
//   wait states and pushes the expected retirement of each instruction into a
//   queue; a negedge monitor pops and checks at every pc_we pulse. Directed
//   sections cover halt, illegal opcode, timeout and reset mid-handshake.
// ----------------------------------------------------------------------------
module tb_ysyx_25020047_ctrl_fsm;

    localparam int TO = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
    logic          inst_latch_en;
    logic [6:0]    opcode = 7'd0;
    logic          is_ebreak = 1'b0;
    logic          dmem_req_valid, dmem_req_ready = 1'b0, dmem_we, dmem_rsp_valid = 1'b0;
    logic          rf_we, pc_we, halted, err;
    logic [CW-1:0] cyc_cnt, inst_cnt;

    always #5 clk = ~clk;

    ysyx_25020047_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .inst_latch_en(inst_latch_en),
        .opcode(opcode), .is_ebreak(is_ebreak),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_rsp_valid(dmem_rsp_valid),
        .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .err(err),
        .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
    );

    typedef struct {
        int lat;     // cycles from first FETCH_REQ cycle to WB inclusive
        bit rf;
        bit mem;
        bit we;
        int dvalid;  // cycles dmem_req_valid is high
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  legal_ops [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc_idx = 0, start_idx = 0, n_latch = 0, n_dval = 0, ret_cnt = 0;
    longint      lat_sum = 0;
    bit          prev_req = 0, seen_we = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 0;
            n_latch  = 0;
            n_dval   = 0;
            ret_cnt  = 0;
            lat_sum  = 0;
            q.delete();
        end else begin
            cyc_idx++;
            if (imem_req_valid && !prev_req) begin
                start_idx = cyc_idx;
                n_latch   = 0;
                n_dval    = 0;
            end
            prev_req = imem_req_valid;
            if (inst_latch_en) n_latch++;
            if (dmem_req_valid) begin
                n_dval++;
                seen_we = dmem_we;
            end
            if (pc_we) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wb: pc_we=1 with no instruction pending");
                end else begin
                    e = q.pop_front();
                    check("wb_latency", 64'(cyc_idx - start_idx + 1), 64'(e.lat));
                    check("wb_rf_we", 64'(rf_we), 64'(e.rf));
                    check("latch_pulses", 64'(n_latch), 64'd1);
                    check("dmem_valid_cycles", 64'(n_dval), 64'(e.dvalid));
                    if (e.mem) check("dmem_we", 64'(seen_we), 64'(e.we));
`ifdef YSYX_25020047_PERF_CNT_EN
                    check("perf_inst_cnt", 64'(inst_cnt), 64'(ret_cnt));
                    check("perf_cyc_cnt", 64'(cyc_cnt), 64'(lat_sum + e.lat - 1));
`else
                    check("perf_inst_cnt", 64'(inst_cnt), 64'd0);
                    check("perf_cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
                    ret_cnt++;
                    lat_sum += e.lat;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit dm, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if ((dm ? dmem_req_valid : imem_req_valid) === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_%s_req: got no request in 50 cycles, expected one", dm ? "dmem" : "imem");
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        dmem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        dmem_rsp_valid = 1'b1;
        is_ebreak      = 1'b0;
        #1;
        check("rst_outputs", 64'({imem_req_valid, inst_latch_en, dmem_req_valid, dmem_we,
                                  rf_we, pc_we, halted, err}), 64'd0);
        check("rst_counters", {cyc_cnt, inst_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;
        // IDLE cycle, stray responses present and ignored
        #1;
        check("idle_outputs", 64'({imem_req_valid, dmem_req_valid, rf_we, pc_we, halted, err}), 64'd0);
        tick();
        dmem_rsp_valid = 1'b0;
    endtask

    // Leaves the DUT in DECODE at return.
    task automatic do_fetch(input logic [6:0] op, input bit ebr, input int rd, input int rs, output bit ok);
        wait_req(0, ok);
        if (!ok) return;
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        repeat (rd) tick();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'($urandom_range(0, 1));
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (rs) tick();
        imem_rsp_valid = 1'b1;
        opcode         = op;
        is_ebreak      = ebr;
        tick();
        imem_rsp_valid = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    task automatic do_mem(input int dr, input int ds, output bit ok);
        wait_req(1, ok);
        if (!ok) return;
        imem_rsp_valid = 1'($urandom_range(0, 1));
        repeat (dr) tick();
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        repeat (ds) tick();
        dmem_rsp_valid = 1'b1;
        tick();
        dmem_rsp_valid = 1'b0;
    endtask

    task automatic run_inst(input logic [6:0] op, input int rd, input int rs, input int dr, input int ds);
        exp_t x;
        bit   ok;
        x.mem    = (op == 7'b0000011) || (op == 7'b0100011);
        x.we     = (op == 7'b0100011);
        x.rf     = !((op == 7'b0100011) || (op == 7'b1100011));
        x.dvalid = x.mem ? dr + 1 : 0;
        x.lat    = (rd + 1) + (rs + 1) + 2 + (x.mem ? (dr + 1) + (ds + 1) : 0) + 1;
        q.push_back(x);
        do_fetch(op, 1'b0, rd, rs, ok);
        if (ok && x.mem) do_mem(dr, ds, ok);
    endtask

    initial begin
        bit ok;
        int busy;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
                      7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011};

        // Directed zero-wait ALU, stalled store, zero-wait load, then random mix.
        do_reset();
        run_inst(7'b0010011, 0, 0, 0, 0);
        run_inst(7'b0100011, 0, 0, 3, 0);
        run_inst(7'b0000011, 0, 0, 0, 0);
        run_inst(7'b1100011, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            run_inst(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 3),
                     $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // ebreak: HALT next cycle, then silence despite noisy inputs.
        do_fetch(7'b1110011, 1'b1, 0, 0, ok);
        tick();
        check("ebreak_halted", 64'({halted, err}), 64'b10);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            dmem_req_ready = 1'($urandom_range(0, 1));
            dmem_rsp_valid = 1'($urandom_range(0, 1));
            #1;
            busy += int'(imem_req_valid | dmem_req_valid | inst_latch_en | rf_we | pc_we);
            tick();
        end
        check("halt_quiet", 64'(busy), 64'd0);
        check("halt_sticky", 64'(halted), 64'd1);
        check("halt_queue_empty", 64'(q.size()), 64'd0);

        // ebreak outranks an illegal opcode.
        do_reset();
        do_fetch(7'b1111111, 1'b1, 0, 0, ok);
        tick();
        check("ebreak_priority", 64'({halted, err}), 64'b10);

        // Illegal opcodes.
        do_reset();
        do_fetch(7'b1111111, 1'b0, 0, 0, ok);
        check("decode_no_err_yet", 64'(err), 64'd0);
        tick();
        check("illegal_err", 64'({halted, err}), 64'b01);
        do_reset();
        do_fetch(7'b0001111, 1'b0, 1, 2, ok);
        tick();
        check("fence_illegal_err", 64'(err), 64'd1);

        // Fetch timeout: 4 response-less FETCH_WAIT cycles.
        do_reset();
        wait_req(0, ok);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        repeat (3) tick();
        check("timeout_not_yet", 64'(err), 64'd0);
        tick();
        check("timeout_err", 64'(err), 64'd1);
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        check("err_sticky", 64'({err, inst_latch_en, imem_req_valid}), 64'b100);

        // Reset in MEM_WAIT, late response, then 3 zero-wait ALU instructions.
        do_reset();
        do_fetch(7'b0000011, 1'b0, 0, 0, ok);
        wait_req(1, ok);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        tick();
        do_reset();
        for (int i = 0; i < 3; i++) run_inst(7'b0110011, 0, 0, 0, 0);
        wait_req(0, ok);
`ifdef YSYX_25020047_PERF_CNT_EN
        check("perf3_inst", 64'(inst_cnt), 64'd3);
        check("perf3_cyc", 64'(cyc_cnt), 64'd15);
`else
        check("perf3_inst", 64'(inst_cnt), 64'd0);
        check("perf3_cyc", 64'(cyc_cnt), 64'd0);
`endif
        check("retired_after_reset", 64'(ret_cnt), 64'd3);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation ran past 2 ms, expected finish");
        $fatal(1, "timeout");
    end

endmodule
